conv_frame_sequencer: RTL
=========================

# conv_frame_sequencer

Frame-level controller for the 3x3 convolution kernel datapath. Accepts a raster-scan pixel stream over a valid/ready handshake. Issues one pixel per strobe to the kernel, replacing the free-running divided clock with a qualified clock enable. Holds the nine kernel coefficients, drains the kernel pipeline at end of frame, and tags each returned result with its window position and validity.

## Interface
Parameters:
- IMG_W, 8: pixels per row (>=3)
- IMG_H, 8: rows per frame (>=3)
- STB_DIV, 6: minimum clk cycles between kernel strobes (>=2)
- LAT, 2: kernel latency in strobes (>=1)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  frame start pulse, honoured only in IDLE
- in_valid  in  1  pixel available
- in_data  in  8  pixel value
- in_ready  out  1  sequencer accepts pixel this cycle
- coef_we  in  1  coefficient write strobe
- coef_addr  in  4  coefficient index 0..8
- coef_data  in  8  coefficient value
- coef_flat  out  72  coefficients, index i at bits [8i+7:8i]
- pix_out  out  8  pixel to kernel, registered
- pix_stb  out  1  one-cycle kernel advance enable
- z_in  in  32  kernel result, valid on the pix_stb cycle
- res_valid  out  1  one-cycle pulse: res_data is a full-window result
- res_data  out  32  captured result
- res_row  out  $clog2(IMG_H)  window bottom-right row
- res_col  out  $clog2(IMG_W)  window bottom-right column
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- States: IDLE, RUN, FLUSH, DONE.
  - IDLE --start--> RUN.
  - RUN --last pixel accepted--> FLUSH.
  - FLUSH --LAT-th flush strobe issued--> DONE.
  - DONE --> IDLE, unconditionally after 1 cycle.
- Divider div_cnt: cleared to 0 on entry to RUN and FLUSH, and on every pix_stb. Increments to STB_DIV-1 and saturates there.
- RUN handshake:
  - in_ready = (state==RUN) && (div_cnt==STB_DIV-1).
  - A transfer occurs when in_valid && in_ready. In the following cycle: pix_out <= in_data and pix_stb=1.
  - in_ready stays high at saturation until in_valid arrives; no strobe is issued while stalled.
- Position counters col/row: advance on each transfer. col wraps IMG_W-1 -> 0 and increments row. The transfer at (IMG_H-1, IMG_W-1) moves the state to FLUSH.
- FLUSH:
  - Each time div_cnt reaches STB_DIV-1, issue pix_stb with pix_out=0. in_ready=0.
  - Exactly LAT flush strobes.
- Tag pipeline: LAT-deep shift register of {ok,row,col}, advanced only on pix_stb.
  - ok = (row>=2 && col>=2) for real pixels; ok=0 for flush entries.
  - On entry to RUN, all entries are cleared to ok=0.
- Result capture: on each pix_stb cycle, the oldest tag pops. The cycle after, res_data <= z_in, res_row/res_col <= popped tag, res_valid <= popped ok.
- Per frame: IMG_W*IMG_H + LAT strobes and (IMG_W-2)*(IMG_H-2) res_valid pulses, in raster order.
- Coefficients:
  - Write accepted only in IDLE with coef_addr<=8. Other writes are ignored.
  - coef_we and start in the same IDLE cycle: the write takes effect and the frame starts.

## Timing
- Reset values:
  - State IDLE; all counters, tags, in_ready, pix_out, pix_stb, res_valid, res_data, res_row, res_col, busy and frame_done = 0.
  - coef_flat = {2,1,2,1,2,1,2,1,2} for index 8..0.
- start at cycle t: RUN from t+1; first in_ready at t+STB_DIV (given in_valid=1).
- Strobe spacing is exactly STB_DIV cycles with no stalls; longer when stalled.
- res_valid is asserted 1 cycle after the pix_stb that returns the result.
- frame_done is asserted in the DONE cycle, which is 1 cycle after the last flush strobe. busy drops the cycle after.
- start outside IDLE is ignored.
- rst_n asserted mid-frame: immediate return to reset values; any partial frame is discarded. The next frame needs a new start.

## Test plan
- Reset: hold rst_n=0 -> all outputs 0, coef_flat = 72'h020102010201020102.
- Coefficient writes:
  - In IDLE, addr 4 data 8'h05 -> coef_flat[39:32]=5.
  - addr 9 -> no change.
  - Write during RUN -> no change.
- IMG_W=4, IMG_H=3, STB_DIV=6, LAT=2, in_valid held 1, pixel k = k+1:
  - first in_ready 6 cycles after start;
  - 14 pix_stb spaced 6 cycles;
  - exactly 2 res_valid with (row,col) = (2,2) then (2,3), res_data = z_in sampled on strobes 12 and 13;
  - frame_done 1 cycle after strobe 13.
- Stall: drop in_valid for 10 cycles before pixel 5 -> in_ready held high, no pix_stb, row/col frozen; the frame then completes normally.
- rst_n pulsed low during pixel 7 -> busy=0, no further strobes; a new start runs a complete correct frame.
- start pulsed during RUN and FLUSH -> ignored; exactly one frame_done.

Source files
------------

// File: rtl/conv_frame_sequencer.sv
// Paces a raster pixel stream into STB_DIV-spaced kernel strobes, holds coefficients, drains the kernel, tags results.
// Pixel reaches pix_out one cycle after transfer; in_ready waits at saturation for in_valid; results lag LAT strobes + 1 cycle.
module conv_frame_sequencer #(
  parameter int IMG_W   = 8,
  parameter int IMG_H   = 8,
  parameter int STB_DIV = 6,
  parameter int LAT     = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [7:0]               in_data,
  output logic                     in_ready,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic [7:0]               coef_data,
  output logic [71:0]              coef_flat,
  output logic [7:0]               pix_out,
  output logic                     pix_stb,
  input  logic [31:0]              z_in,
  output logic                     res_valid,
  output logic [31:0]              res_data,
  output logic [$clog2(IMG_H)-1:0] res_row,
  output logic [$clog2(IMG_W)-1:0] res_col,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);
  localparam int DW = $clog2(STB_DIV);
  localparam int FW = $clog2(LAT + 1);
  localparam logic [DW-1:0] DIV_MAX  = DW'(STB_DIV - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [FW-1:0] FLUSH_N  = FW'(LAT);
  localparam logic [71:0]   COEF_RST = 72'h020102010201020102;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  typedef struct packed {
    logic          ok;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } tag_t;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [FW-1:0] flush_q, flush_d;
  logic [7:0]    pix_q, pix_d;
  logic          stb_q, stb_d;
  tag_t          stb_tag_q, stb_tag_d;
  tag_t          tag_q [LAT];
  tag_t          tag_d [LAT];
  tag_t          pop;
  logic          res_vld_q, res_vld_d;
  logic [31:0]   res_dat_q, res_dat_d;
  logic [RW-1:0] res_row_q, res_row_d;
  logic [CW-1:0] res_col_q, res_col_d;
  logic [71:0]   coef_q, coef_d;
  logic          xfer;

  assign in_ready   = (state_q == RUN) && (div_q == DIV_MAX);
  assign xfer       = in_valid && in_ready;
  assign coef_flat  = coef_q;
  assign pix_out    = pix_q;
  assign pix_stb    = stb_q;
  assign res_valid  = res_vld_q;
  assign res_data   = res_dat_q;
  assign res_row    = res_row_q;
  assign res_col    = res_col_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    col_d     = col_q;
    row_d     = row_q;
    flush_d   = flush_q;
    pix_d     = pix_q;
    stb_d     = 1'b0;
    stb_tag_d = stb_tag_q;
    tag_d     = tag_q;
    res_vld_d = 1'b0;
    res_dat_d = res_dat_q;
    res_row_d = res_row_q;
    res_col_d = res_col_q;
    coef_d    = coef_q;
    pop       = tag_q[LAT-1];

    if (div_q != DIV_MAX) begin
      div_d = div_q + DW'(1);
    end

    // The strobe cycle carries the kernel result belonging to the oldest tag.
    if (stb_q) begin
      res_vld_d = pop.ok;
      res_dat_d = z_in;
      res_row_d = pop.row;
      res_col_d = pop.col;
      for (int i = LAT - 1; i > 0; i--) begin
        tag_d[i] = tag_q[i-1];
      end
      tag_d[0] = stb_tag_q;
    end

    case (state_q)
      IDLE: begin
        if (coef_we) begin
          for (int i = 0; i < 9; i++) begin
            if (coef_addr == 4'(i)) begin
              coef_d[8*i +: 8] = coef_data;
            end
          end
        end
        if (start) begin
          state_d   = RUN;
          div_d     = '0;
          col_d     = '0;
          row_d     = '0;
          flush_d   = '0;
          stb_tag_d = '0;
          for (int i = 0; i < LAT; i++) begin
            tag_d[i] = '0;
          end
        end
      end

      RUN: begin
        if (xfer) begin
          pix_d         = in_data;
          stb_d         = 1'b1;
          div_d         = '0;
          stb_tag_d.ok  = (row_q >= RW'(2)) && (col_q >= CW'(2));
          stb_tag_d.row = row_q;
          stb_tag_d.col = col_q;
          if (col_q == COL_LAST) begin
            col_d = '0;
            if (row_q == ROW_LAST) begin
              row_d   = '0;
              state_d = FLUSH;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end

      FLUSH: begin
        // Zero pixels push the last real results out of the kernel pipeline.
        if ((div_q == DIV_MAX) && (flush_q != FLUSH_N)) begin
          pix_d     = 8'd0;
          stb_d     = 1'b1;
          div_d     = '0;
          stb_tag_d = '0;
          flush_d   = flush_q + FW'(1);
        end
        if (stb_q && (flush_q == FLUSH_N)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      flush_q   <= '0;
      pix_q     <= '0;
      stb_q     <= 1'b0;
      stb_tag_q <= '0;
      tag_q     <= '{default: '0};
      res_vld_q <= 1'b0;
      res_dat_q <= '0;
      res_row_q <= '0;
      res_col_q <= '0;
      coef_q    <= COEF_RST;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      col_q     <= col_d;
      row_q     <= row_d;
      flush_q   <= flush_d;
      pix_q     <= pix_d;
      stb_q     <= stb_d;
      stb_tag_q <= stb_tag_d;
      tag_q     <= tag_d;
      res_vld_q <= res_vld_d;
      res_dat_q <= res_dat_d;
      res_row_q <= res_row_d;
      res_col_q <= res_col_d;
      coef_q    <= coef_d;
    end
  end

endmodule
